// File: rtl/sv_fetch_sequencer_pkg.sv
// Shared definitions for the SVM support-vector fetch path.
package svm_pkg;

  localparam int BLOCK_LENGTH  = 9;
  localparam int VECTOR_LENGTH = 16;
  localparam int NUM_VECTORS   = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Ceiling log2, never below 1 so degenerate sizes still give a legal width.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sv_fetch_sequencer_if.sv
// ROM read port plus element stream towards the MAC datapath.
interface sv_fetch_sequencer_if
  import svm_pkg::*;
#(
  parameter int blockLength  = BLOCK_LENGTH,
  parameter int vectorLength = VECTOR_LENGTH,
  parameter int numVectors   = NUM_VECTORS
);
  localparam int memDepth        = vectorLength * numVectors;
  localparam int addressBitWidth = log2(memDepth);
  localparam int indexBitWidth   = log2(numVectors);

  logic                       rom_enable;
  logic [addressBitWidth-1:0] rom_address;
  logic [blockLength-1:0]     rom_data;
  logic [blockLength-1:0]     sv_data;
  logic                       sv_valid;
  logic                       sv_ready;
  logic                       sv_first;
  logic                       sv_last;
  logic [indexBitWidth-1:0]   sv_index;

  modport master (
    output rom_enable, rom_address, sv_data, sv_valid, sv_first, sv_last, sv_index,
    input  rom_data, sv_ready
  );

  modport slave (
    input  rom_enable, rom_address, sv_data, sv_valid, sv_first, sv_last, sv_index,
    output rom_data, sv_ready
  );

endinterface

// File: rtl/sv_skid_fifo.sv
// Two-entry register FIFO absorbing the ROM read latency under backpressure.
module sv_skid_fifo #(
  parameter int width = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [1:0][width-1:0] mem;
  logic                  wr_ptr, rd_ptr;
  logic                  push_ok, pop_ok;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign pop_ok  = pop && !empty;
  // A write into a full FIFO is legal only while the head leaves the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy; flush drops contents without touching storage.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/sv_fetch_sequencer.sv
// Linear ROM walker framing support vectors onto a valid/ready stream.
module sv_fetch_sequencer
  import svm_pkg::*;
#(
  parameter int blockLength  = BLOCK_LENGTH,
  parameter int vectorLength = VECTOR_LENGTH,
  parameter int numVectors   = NUM_VECTORS
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  sv_fetch_sequencer_if.master  bus
);

  localparam int memDepth        = vectorLength * numVectors;
  localparam int addressBitWidth = log2(memDepth);
  localparam int indexBitWidth   = log2(numVectors);
  localparam int elemBitWidth    = log2(vectorLength);
  localparam int tagWidth        = 2 + indexBitWidth;
  localparam int payloadWidth    = blockLength + tagWidth;

  state_t                     state_q, state_d;
  logic [addressBitWidth-1:0] addr_q;
  logic [elemBitWidth-1:0]    elem_q;
  logic [indexBitWidth-1:0]   vec_q;
  logic                       inflight_q;
  logic [tagWidth-1:0]        tag_q;

  logic                       issue, last_issue, pop;
  logic                       fifo_full, fifo_empty;
  logic [1:0]                 fifo_count;
  logic [payloadWidth-1:0]    head;

  assign pop        = !fifo_empty && bus.sv_ready;
  // At most two words are ever owed to the FIFO, so it can never overflow.
  assign issue      = (state_q == FETCH) && !abort &&
                      ((({1'b0, fifo_count} + {2'b0, inflight_q}) < 3'd2) || pop);
  assign last_issue = issue && (addr_q == addressBitWidth'(memDepth - 1));

  assign bus.rom_enable  = issue;
  assign bus.rom_address = addr_q;
  assign bus.sv_valid    = !fifo_empty;
  assign {bus.sv_data, bus.sv_first, bus.sv_last, bus.sv_index} = head;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // Next-state: abort wins over everything, DRAIN ends on the final accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (pop && !inflight_q && fifo_count == 2'd1) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Address/element/vector counters and the tag of the read in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      elem_q     <= '0;
      vec_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else if (abort) begin
      addr_q     <= '0;
      elem_q     <= '0;
      vec_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (state_q == IDLE && start) begin
        addr_q <= '0;
        elem_q <= '0;
        vec_q  <= '0;
      end
      if (issue) begin
        tag_q <= {elem_q == '0, elem_q == elemBitWidth'(vectorLength - 1), vec_q};
        // Hold the final address so the port shows the last word read.
        if (!last_issue) addr_q <= addr_q + 1'b1;
        if (elem_q == elemBitWidth'(vectorLength - 1)) begin
          elem_q <= '0;
          vec_q  <= vec_q + 1'b1;
        end else begin
          elem_q <= elem_q + 1'b1;
        end
      end
    end
  end

  // A word returning after an abort is dropped by gating the push.
  sv_skid_fifo #(.width(payloadWidth)) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .flush  (abort),
    .push   (inflight_q && !abort),
    .wdata  ({bus.rom_data, tag_q}),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_sv_fetch_sequencer.sv
// Directed bench: small 3x4 ROM, ready patterns, abort, restart, async reset.
module tb_sv_fetch_sequencer;
  import svm_pkg::*;

  localparam int BL = 9;
  localparam int VL = 4;
  localparam int NV = 3;
  localparam int MD = VL * NV;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  sv_fetch_sequencer_if #(.blockLength(BL), .vectorLength(VL), .numVectors(NV)) bus ();

  sv_fetch_sequencer #(.blockLength(BL), .vectorLength(VL), .numVectors(NV)) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .bus    (bus.master)
  );

  // ROM model: ROM[i] = i, one-cycle registered read.
  always_ff @(posedge clock)
    if (bus.rom_enable) bus.rom_data <= BL'(bus.rom_address);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_valid"}, bus.sv_valid, 0);
    chk({tag, "_ren"},   bus.rom_enable, 0);
  endtask

  // mode 0: ready high; 1: LFSR ready; 2: ready low cycles 1..20; 3: ready high + stray start at cycle 6
  task automatic run(input int mode);
    int acc, dcnt, issued, maxb, lastacc, maxc;
    logic [7:0] lfsr;
    logic stall, rdy;
    logic [BL-1:0] pdata;
    acc = 0; dcnt = 0; issued = 0; maxb = 0; lastacc = -1;
    lfsr = 8'hA5; stall = 1'b0; pdata = '0;
    maxc = (mode == 1) ? 80 : (mode == 2) ? 40 : 18;
    @(negedge clock);
    start = 1'b1;
    bus.sv_ready = (mode != 2);
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clock);
      start = (mode == 3 && c == 6);
      case (mode)
        1: begin
          lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          rdy  = lfsr[0];
        end
        2:       rdy = (c > 20);
        default: rdy = 1'b1;
      endcase
      bus.sv_ready = rdy;
      #1;
      if (stall) begin
        chk("stall_valid", bus.sv_valid, 1);
        chk("stall_data", bus.sv_data, pdata);
      end
      if (bus.rom_enable) begin
        chk("rom_addr", bus.rom_address, issued);
        issued++;
      end
      if (mode == 2 && c == 20) chk("stall_reads", issued, 2);
      if (mode == 0 || mode == 3) begin
        chk("valid_t", bus.sv_valid, (c >= 3 && c <= 14));
        chk("done_t", done, (c == 15));
        chk("busy_t", busy, (c <= 15));
      end
      if (bus.sv_valid && rdy) begin
        chk("data",  bus.sv_data, acc);
        chk("first", bus.sv_first, (acc % VL) == 0);
        chk("last",  bus.sv_last, (acc % VL) == VL - 1);
        chk("index", bus.sv_index, acc / VL);
        acc++;
        lastacc = c;
      end
      if (issued - acc > maxb) maxb = issued - acc;
      if (done) dcnt++;
      stall = bus.sv_valid && !rdy;
      pdata = bus.sv_data;
    end
    chk("accepted", acc, MD);
    chk("done_cnt", dcnt, 1);
    chk("overrun", maxb > 2, 0);
    chk("end_busy", busy, 0);
    if (mode == 2) chk("release_last", lastacc, 32);
  endtask

  initial begin
    bus.sv_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk_idle_outputs("reset");
    chk("reset_addr", bus.rom_address, 0);
    chk("reset_data", bus.sv_data, 0);
    resetn = 1'b1;
    @(negedge clock);

    run(0);
    run(1);
    run(2);

    // Abort in the cycle after address 5 is issued.
    @(negedge clock);
    start = 1'b1;
    bus.sv_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      start = 1'b0;
      abort = (c == 7);
      #1;
      if (c == 6) begin
        chk("abort_ren5", bus.rom_enable, 1);
        chk("abort_addr5", bus.rom_address, 5);
      end
    end
    for (int c = 8; c <= 12; c++) begin
      @(negedge clock);
      abort = 1'b0;
      #1;
      chk_idle_outputs("abort");
    end
    run(0);

    run(3);

    // Asynchronous reset mid-run.
    @(negedge clock);
    start = 1'b1;
    bus.sv_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    #2;
    resetn = 1'b0;
    #1;
    chk_idle_outputs("areset");
    chk("areset_addr",  bus.rom_address, 0);
    chk("areset_data",  bus.sv_data, 0);
    chk("areset_first", bus.sv_first, 0);
    chk("areset_last",  bus.sv_last, 0);
    chk("areset_index", bus.sv_index, 0);
    @(negedge clock);
    resetn = 1'b1;
    run(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sv_fetch_sequencer.md
# sv_fetch_sequencer

Read sequencer for the SVM support-vector ROM. On `start` it walks the ROM linearly, one support vector after another, and drives its `enable`/`address` port. It compensates for the ROM's 1-cycle registered read latency and streams elements to the SVM MAC datapath over a valid/ready interface with full backpressure. The ROM itself stays external. This block owns only sequencing, flow control and vector framing.

## Interface
Parameters:
- `blockLength`, 9: data width of one ROM word / SV element.
- `vectorLength`, 16: elements per support vector.
- `numVectors`, 25: support vectors per run.
- `memDepth`, `vectorLength*numVectors` (localparam): words read per run.
- `addressBitWidth`, `log2(memDepth)` (localparam, ceil): ROM address width.
- `indexBitWidth`, `log2(numVectors)` (localparam, ceil): vector index width.

Ports:
- `clock` in 1: single clock, rising edge. Asynchronous active-low reset is `resetn`.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a run; honoured only in IDLE.
- `abort` in 1: synchronous flush, returns to IDLE.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last element is accepted.
- `rom_enable` out 1: ROM read enable.
- `rom_address` out addressBitWidth: ROM read address.
- `rom_data` in blockLength: ROM output, valid 1 cycle after an enabled read.
- `sv_data` out blockLength: element to datapath.
- `sv_valid` out 1: `sv_data` valid.
- `sv_ready` in 1: datapath accepts when `sv_valid && sv_ready`.
- `sv_first` out 1: element 0 of a vector (qualified by `sv_valid`).
- `sv_last` out 1: element vectorLength-1 of a vector.
- `sv_index` out indexBitWidth: vector number of the current element.

## Operation
- FSM states:
  - IDLE -> FETCH on `start`.
  - FETCH -> DRAIN after issuing address memDepth-1.
  - DRAIN -> DONE when the final element is accepted.
  - DONE -> IDLE unconditionally after 1 cycle, with `done`=1 in DONE.
- Issue rule in FETCH: `rom_enable`=1 when (inflight + fifo_count) < 2, or when a pop occurs this cycle. Each issue increments `rom_address`.
  - inflight is 1 exactly in the cycle after an issue.
- Returned words are written into a 2-entry FIFO, tagged with first/last/index computed at issue time.
- The FIFO head drives `sv_data`/`sv_first`/`sv_last`/`sv_index`/`sv_valid`. Outputs are stable while `sv_valid && !sv_ready`.
- Element and vector counters use no division: element wraps vectorLength-1 -> 0 and increments vector.
- `rom_enable`=0 outside issue cycles; `rom_address` holds its last value.
- `start` while busy is ignored.
- `abort` in any state, on the next edge:
  - go to IDLE and clear the FIFO, counters and inflight;
  - discard a ROM word returning in the following cycle;
  - no `done`.
  - `abort` has priority over `start` in the same cycle.
- Reset: all outputs 0, `rom_address`=0, FSM IDLE, FIFO empty.

## Timing
- `start` sampled at edge 0 -> first `rom_enable` in cycle 1, address 0.
- Address 0 data lands in the FIFO at edge 3 -> `sv_valid` from cycle 3.
- With `sv_ready` held high, throughput is 1 element/cycle. Last element in cycle memDepth+2, `done` in cycle memDepth+3, `busy` low from cycle memDepth+4.
- `sv_ready` low: at most 2 reads beyond the last accepted element; no word is lost or duplicated.

## Structure
- Shared package `svm_pkg`: `log2` function; default `blockLength`/`vectorLength`/`numVectors`; FSM state encoding (IDLE=0, FETCH=1, DRAIN=2, DONE=3).
- Sub-module `sv_skid_fifo`: 2-entry register FIFO with async active-low reset and synchronous flush.
  - Payload: blockLength+2+indexBitWidth.
  - Flags: `full`, `empty`, `count`.

## Test plan
- vectorLength=4, numVectors=3, ROM[i]=i, `sv_ready`=1, `start` -> sv_data 0..11 in cycles 3..14; `sv_first` on 0,4,8; `sv_last` on 3,7,11; `sv_index` 0,0,0,0,1,...,2; `done` in cycle 15.
- Same run with `sv_ready` toggling on an LFSR -> accepted sequence exactly 0..11; no more than 2 reads beyond the last accepted element; `sv_data` stable while stalled.
- `sv_ready`=0 for 20 cycles after `start` -> exactly 2 `rom_enable` pulses (addresses 0, 1); on release, data 0, 1, 2... continuous.
- `abort` in the cycle after address 5 is issued -> next cycle `busy`=0, `sv_valid`=0, no `done`. A following `start` restarts at address 0 with data 0.
- `start` pulsed again at cycle 6 of a run -> ignored; single run of 12 elements and one `done`.
- `resetn` low mid-run (asynchronous) -> all outputs 0 immediately, IDLE; a new `start` after release gives a clean run.
